// File: rtl/alu_entry_pkg.sv
// Shared definitions for the ALU operand entry block: state encodings and debounce default.
package alu_entry_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_e;

endpackage

// File: rtl/alu_operand_entry_button_debounce.sv
// Two-flop synchroniser, stable-count debouncer and registered rising-edge pulse for one button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      pulse        <= 1'b0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      pulse        <= level_q & ~level_prev_q;
      // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
      if (sync2_q != level_q) begin
        if (cnt_q == CntLast) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_entry.sv
// Button-driven entry of adder operands A, B and mode/carry bits from four switches.
module alu_operand_entry
  import alu_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       s0,
  output logic       s1,
  output logic       cin,
  output logic       valid,
  output logic [1:0] state_led
);

  state_e state;
  logic   enter_pulse, clear_pulse;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_enter),
    .pulse(enter_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_clear),
    .pulse(clear_pulse)
  );

  // Clear wins over a coincident enter.
  always_ff @(posedge clk) begin
    if (rst || clear_pulse) begin
      state <= LOAD_A;
      a     <= 4'h0;
      b     <= 4'h0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      cin   <= 1'b0;
      valid <= 1'b0;
    end else if (enter_pulse) begin
      unique case (state)
        LOAD_A: begin
          a     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: begin
          s0    <= sw[0];
          s1    <= sw[1];
          cin   <= sw[2];
          valid <= 1'b1;
          state <= SHOW;
        end
        SHOW: begin
          valid <= 1'b0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign state_led = state;

endmodule
